// File: rtl/bec_seq_p.sv
// bec_seq_p: falling-edge channel issue sequencer with per-beat ack timeout and error hold.
// Define BEC_SEQ_ACT_MON_EN to enable the saturating activation counter and alarm.
module bec_seq_p #(
  parameter int NCH    = 4,
  parameter int TMO    = 15,
  parameter int CNT_W  = 8,
  parameter int THRESH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ch_sel,
  input  logic [1:0]       mode,
  input  logic [NCH-1:0]   ack,
  input  logic             clr,
  output logic [NCH-1:0]   issue,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] act_cnt,
  output logic             act_alarm
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISSUE  = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] FINISH = 3'd3;
  localparam logic [2:0] ERROR  = 3'd4;
  localparam logic [4:0] NCH_V  = 5'(NCH);
  localparam logic [7:0] TMO_V  = 8'(TMO);
  logic [2:0]     state, nxt;
  logic [7:0]     tmr;
  logic [1:0]     beat, mode_q;
  logic [3:0]     ch_q;
  logic [NCH-1:0] sel_oh;
  logic           ack_hit;
  assign sel_oh  = NCH'(1) << ch_q;
  assign ack_hit = |(ack & sel_oh);
  always_ff @(negedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= nxt;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = !start ? IDLE : ({1'b0, ch_sel} < NCH_V) ? ISSUE : ERROR;
      ISSUE:   nxt = WAIT;
      // ack wins over an expiring timer in the same cycle
      WAIT:    nxt = ack_hit ? FINISH : (tmr <= 8'd1) ? ERROR : WAIT;
      FINISH:  nxt = (beat < mode_q) ? ISSUE : IDLE;
      ERROR:   nxt = clr ? IDLE : ERROR;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    issue = (state == ISSUE) ? sel_oh : '0;
    busy  = state != IDLE;
    done  = state == FINISH;
    err   = state == ERROR;
  end
  always_ff @(negedge clk or negedge rst)
    if (!rst) begin
      tmr    <= '0;
      beat   <= '0;
      ch_q   <= '0;
      mode_q <= '0;
    end else begin
      if (state == IDLE && start) begin
        ch_q   <= ch_sel;
        mode_q <= mode;
        beat   <= '0;
      end
      if (state == ISSUE) tmr <= TMO_V;
      else if (state == WAIT && !ack_hit) tmr <= tmr - 8'd1;
      if (state == FINISH && beat < mode_q) beat <= beat + 2'd1;
    end
`ifdef BEC_SEQ_ACT_MON_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(negedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (state == WAIT && nxt == FINISH && cnt != '1) cnt <= cnt + CNT_W'(1);
  assign act_cnt   = cnt;
  assign act_alarm = 32'(cnt) >= 32'(THRESH);
`else
  assign act_cnt   = '0;
  assign act_alarm = 1'b0;
`endif
endmodule

// File: tb/tb_bec_seq_p.sv
// tb_bec_seq_p: directed bench for bec_seq_p; inputs change on posedge, DUT acts on negedge.
module tb_bec_seq_p;
  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, clr = 1'b0;
  logic [3:0] ch_sel = '0, ack = '0;
  logic [1:0] mode = '0;
  logic [3:0] issue, issue3;
  logic       busy, done, err, act_alarm, busy3, done3, err3, act_alarm3;
  logic [7:0] act_cnt;
  logic [2:0] act_cnt3;
  int         n_chk = 0, n_pass = 0;
  int         ni, nd, nb;
  always #5 clk = ~clk;
  bec_seq_p dut (
    .clk(clk), .rst(rst), .start(start), .ch_sel(ch_sel), .mode(mode), .ack(ack), .clr(clr),
    .issue(issue), .busy(busy), .done(done), .err(err), .act_cnt(act_cnt), .act_alarm(act_alarm)
  );
  bec_seq_p #(.CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .ch_sel(ch_sel), .mode(mode), .ack(ack), .clr(clr),
    .issue(issue3), .busy(busy3), .done(done3), .err(err3), .act_cnt(act_cnt3), .act_alarm(act_alarm3)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
  endtask
  task automatic basic(input string tag);
    ch_sel = 4'd2; mode = 2'd0; ack = '0; start = 1'b1;
    step(); start = 1'b0;
    chk({tag, "_issue"}, issue, 4'b0100);
    chk({tag, "_busy"}, busy, 1);
    step();
    chk({tag, "_issue_off"}, issue, 0);
    step(2); ack = 4'b0100;
    chk({tag, "_no_early_done"}, done, 0);
    step(); ack = '0;
    chk({tag, "_done"}, done, 1);
    step();
    chk({tag, "_done_off"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask
  // start and ch_sel/mode are perturbed mid-transaction; both must be ignored
  task automatic txn(input logic [3:0] ch, input logic [1:0] md, output int n_iss, output int n_dn, output int n_busy);
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    n_iss = 0; n_dn = 0; n_busy = 0;
    ch_sel = ch; mode = md; ack = oh; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      ch_sel = ch ^ 4'd1; mode = ~md;
      if (!busy) break;
      n_busy++;
      if (issue == oh) n_iss++;
      if (done) n_dn++;
    end
    start = 1'b0; ack = '0;
    chk("txn_end_idle", busy, 0);
  endtask
  task automatic timeout_run(input logic [3:0] ak, input string tag);
    ch_sel = 4'd0; mode = 2'd0; ack = ak; start = 1'b1;
    step(); start = 1'b0;
    chk({tag, "_issue"}, issue, 4'b0001);
    step(15);
    chk({tag, "_err_early"}, err, 0);
    step();
    chk({tag, "_err"}, err, 1);
    step(3);
    chk({tag, "_err_held"}, {busy, err}, 2'b11);
    clr = 1'b1;
    step(); clr = 1'b0; ack = '0;
    chk({tag, "_cleared"}, {busy, err}, 2'b00);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #1;
    chk("reset_outputs", {issue, busy, done, err, act_alarm}, 0);
    chk("reset_act_cnt", act_cnt, 0);
    step(2); rst = 1'b1;
    step();
    basic("single");
    txn(4'd1, 2'd3, ni, nd, nb);
    chk("multi_issue", ni, 4);
    chk("multi_done", nd, 4);
    chk("multi_busy", nb, 12);
    timeout_run(4'b0000, "tmo");
    ch_sel = 4'd9; mode = 2'd0; start = 1'b1;
    step(); start = 1'b0;
    chk("badch_err", err, 1);
    chk("badch_issue", issue, 0);
    step(2);
    chk("badch_held", err, 1);
    clr = 1'b1;
    step(); clr = 1'b0;
    chk("badch_cleared", {busy, err}, 2'b00);
    timeout_run(4'b1000, "wrong_ack");
    ch_sel = 4'd3; mode = 2'd0; ack = '0; start = 1'b1;
    step(); start = 1'b0;
    chk("rst_pre_issue", issue, 4'b1000);
    step(2);
    #2 rst = 1'b0;
    #1 chk("rst_async", {issue, busy, done, err, act_alarm}, 0);
    step();
    chk("rst_no_done", {busy, done}, 2'b00);
    rst = 1'b1;
    step();
    basic("after_rst");
    rst = 1'b0;
    step(); rst = 1'b1;
    step();
    for (int k = 1; k <= 9; k++) begin
      txn(4'd2, 2'd0, ni, nd, nb);
      chk("act_txn_done", nd, 1);
`ifdef BEC_SEQ_ACT_MON_EN
      chk("act_cnt", act_cnt, k);
      chk("act_alarm", act_alarm, (k >= 5) ? 1 : 0);
      chk("act_cnt_sat", act_cnt3, (k > 7) ? 7 : k);
`else
      chk("act_cnt_off", act_cnt, 0);
      chk("act_alarm_off", act_alarm, 0);
      chk("act_cnt3_off", act_cnt3, 0);
`endif
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
